// File: rtl/iguana_hyper_cfg_seq.sv
// Boot-time HyperBus config writer and status poller; gates SoC regbus until the PHY is ready.
// Latency: table writes issue back to back, polls are spaced by PollGap idle cycles; pass-through adds zero cycles.
// Backpressure: each request is held until hyp_rsp_ready_i; SoC requests stall (soc_rsp_ready_o=0) until DONE/FAIL.
module iguana_hyper_cfg_seq #(
    parameter int unsigned                NumCfg   = 4,
    parameter logic [NumCfg-1:0][11:0]    CfgOffs  = {12'hC, 12'h8, 12'h4, 12'h0},
    parameter logic [NumCfg-1:0][31:0]    CfgData  = {32'h0000_00A5, 32'h0000_1F00, 32'h8000_0003, 32'h0000_0011},
    parameter logic [47:0]                BaseAddr = 48'h0000_2000_2000,
    parameter logic [11:0]                PollOffs = 12'h010,
    parameter logic [31:0]                PollMask = 32'h0000_0001,
    parameter int unsigned                PollGap  = 16,
    parameter int unsigned                MaxPolls = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rerun_i,
    input  logic        soc_req_valid_i,
    input  logic        soc_req_write_i,
    input  logic [47:0] soc_req_addr_i,
    input  logic [31:0] soc_req_wdata_i,
    input  logic [3:0]  soc_req_wstrb_i,
    output logic        soc_rsp_ready_o,
    output logic [31:0] soc_rsp_rdata_o,
    output logic        soc_rsp_error_o,
    output logic        hyp_req_valid_o,
    output logic        hyp_req_write_o,
    output logic [47:0] hyp_req_addr_o,
    output logic [31:0] hyp_req_wdata_o,
    output logic [3:0]  hyp_req_wstrb_o,
    input  logic        hyp_rsp_ready_i,
    input  logic [31:0] hyp_rsp_rdata_i,
    input  logic        hyp_rsp_error_i,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned IdxW = (NumCfg > 1) ? $clog2(NumCfg) : 1;
    localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumCfg - 1);
    localparam logic [GapW-1:0] GapLast    = GapW'(PollGap - 1);
    localparam logic [7:0]      MaxPollCnt = 8'(MaxPolls);
    localparam logic [47:0]     PollAddr   = BaseAddr + {36'd0, PollOffs};

    typedef enum logic [2:0] {
        ST_WRITE,
        ST_POLL,
        ST_GAP,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t          state;
    logic [IdxW-1:0] idx;
    logic [7:0]      pcnt;
    logic [GapW-1:0] gcnt;
    logic            rerun_pend;

    // Sequencer-owned request, registered so reset forces every request line low.
    logic        seq_vld;
    logic        seq_write;
    logic [47:0] seq_addr;
    logic [31:0] seq_wdata;
    logic [3:0]  seq_wstrb;
    logic        done_q;
    logic        error_q;

    logic [IdxW-1:0] idx_nxt;
    logic [7:0]      pcnt_nxt;
    logic            poll_ok;
    logic            pass;
    logic            rerun_go;

    function automatic logic [47:0] cfg_addr(input logic [IdxW-1:0] i);
        return BaseAddr + {36'd0, CfgOffs[i]};
    endfunction

    assign idx_nxt  = idx + 1'b1;
    assign pcnt_nxt = pcnt + 8'd1;
    assign poll_ok  = ((hyp_rsp_rdata_i & PollMask) == PollMask);
    assign pass     = (state == ST_DONE) || (state == ST_FAIL);
    // A rerun only starts in a cycle with no SoC request, so a pass-through transfer is never cut.
    assign rerun_go = (rerun_i || rerun_pend) && !soc_req_valid_i;

    // Sequencer FSM: table writes, status polling with idle gaps, then park in DONE/FAIL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_WRITE;
            idx        <= '0;
            pcnt       <= '0;
            gcnt       <= '0;
            rerun_pend <= 1'b0;
            seq_vld    <= 1'b0;
            seq_write  <= 1'b0;
            seq_addr   <= '0;
            seq_wdata  <= '0;
            seq_wstrb  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                ST_WRITE: begin
                    rerun_pend <= 1'b0;
                    if (!seq_vld) begin
                        seq_vld   <= 1'b1;
                        seq_write <= 1'b1;
                        seq_addr  <= cfg_addr(idx);
                        seq_wdata <= CfgData[idx];
                        seq_wstrb <= 4'hF;
                    end else if (hyp_rsp_ready_i) begin
                        if (hyp_rsp_error_i) begin
                            state     <= ST_FAIL;
                            error_q   <= 1'b1;
                            seq_vld   <= 1'b0;
                            seq_write <= 1'b0;
                            seq_addr  <= '0;
                            seq_wdata <= '0;
                            seq_wstrb <= '0;
                        end else if (idx == LastIdx) begin
                            // Last write done: the first poll follows with valid kept high.
                            state     <= ST_POLL;
                            idx       <= '0;
                            seq_write <= 1'b0;
                            seq_addr  <= PollAddr;
                            seq_wdata <= '0;
                            seq_wstrb <= '0;
                        end else begin
                            idx       <= idx_nxt;
                            seq_addr  <= cfg_addr(idx_nxt);
                            seq_wdata <= CfgData[idx_nxt];
                        end
                    end
                end
                ST_POLL: begin
                    if (!seq_vld) begin
                        seq_vld   <= 1'b1;
                        seq_write <= 1'b0;
                        seq_addr  <= PollAddr;
                        seq_wdata <= '0;
                        seq_wstrb <= '0;
                    end else if (hyp_rsp_ready_i) begin
                        seq_vld  <= 1'b0;
                        seq_addr <= '0;
                        if (hyp_rsp_error_i) begin
                            state   <= ST_FAIL;
                            error_q <= 1'b1;
                        end else if (poll_ok) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            pcnt <= pcnt_nxt;
                            gcnt <= '0;
                            if (pcnt_nxt == MaxPollCnt) begin
                                state   <= ST_FAIL;
                                error_q <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gcnt == GapLast) begin
                        state     <= ST_POLL;
                        seq_vld   <= 1'b1;
                        seq_write <= 1'b0;
                        seq_addr  <= PollAddr;
                        seq_wdata <= '0;
                        seq_wstrb <= '0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                ST_DONE, ST_FAIL: begin
                    if (rerun_go) begin
                        state      <= ST_WRITE;
                        idx        <= '0;
                        pcnt       <= '0;
                        gcnt       <= '0;
                        rerun_pend <= 1'b0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end else if (rerun_i) begin
                        rerun_pend <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_WRITE;
                    seq_vld <= 1'b0;
                end
            endcase
        end
    end

    // Once parked, the SoC owns the HyperBus regbus directly in both directions.
    assign hyp_req_valid_o = pass ? soc_req_valid_i : seq_vld;
    assign hyp_req_write_o = pass ? soc_req_write_i : seq_write;
    assign hyp_req_addr_o  = pass ? soc_req_addr_i  : seq_addr;
    assign hyp_req_wdata_o = pass ? soc_req_wdata_i : seq_wdata;
    assign hyp_req_wstrb_o = pass ? soc_req_wstrb_i : seq_wstrb;

    assign soc_rsp_ready_o = pass & hyp_rsp_ready_i;
    assign soc_rsp_rdata_o = pass ? hyp_rsp_rdata_i : 32'd0;
    assign soc_rsp_error_o = pass & hyp_rsp_error_i;

    assign done_o  = done_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_iguana_hyper_cfg_seq.sv
// Bench for iguana_hyper_cfg_seq: a HyperBus slave model logs every completed transfer,
// compared against the transfer list expected from the boot-sequence rules.
// SoC transfers are driven through the pass-through once the sequence has parked.
module tb_iguana_hyper_cfg_seq;

    localparam logic [47:0] BASE = 48'h0000_2000_2000;
    localparam int NCFG = 4;
    localparam int MAXP = 255;
    localparam logic [3:0][31:0] CFG_PK = {32'hC0DE_0003, 32'hB00B_0002, 32'hA5A5_0001, 32'h1234_5670};
    localparam logic [31:0] CFG_TBL [4] = '{32'h1234_5670, 32'hA5A5_0001, 32'hB00B_0002, 32'hC0DE_0003};

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        rerun_i;
    logic        soc_req_valid_i, soc_req_write_i;
    logic [47:0] soc_req_addr_i;
    logic [31:0] soc_req_wdata_i;
    logic [3:0]  soc_req_wstrb_i;
    logic        soc_rsp_ready_o, soc_rsp_error_o;
    logic [31:0] soc_rsp_rdata_o;
    logic        hyp_req_valid_o, hyp_req_write_o;
    logic [47:0] hyp_req_addr_o;
    logic [31:0] hyp_req_wdata_o;
    logic [3:0]  hyp_req_wstrb_o;
    logic        hyp_rsp_ready_i, hyp_rsp_error_i;
    logic [31:0] hyp_rsp_rdata_i;
    logic        done_o, error_o;

    iguana_hyper_cfg_seq #(.CfgData(CFG_PK)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .rerun_i(rerun_i),
        .soc_req_valid_i(soc_req_valid_i), .soc_req_write_i(soc_req_write_i),
        .soc_req_addr_i(soc_req_addr_i), .soc_req_wdata_i(soc_req_wdata_i),
        .soc_req_wstrb_i(soc_req_wstrb_i),
        .soc_rsp_ready_o(soc_rsp_ready_o), .soc_rsp_rdata_o(soc_rsp_rdata_o),
        .soc_rsp_error_o(soc_rsp_error_o),
        .hyp_req_valid_o(hyp_req_valid_o), .hyp_req_write_o(hyp_req_write_o),
        .hyp_req_addr_o(hyp_req_addr_o), .hyp_req_wdata_o(hyp_req_wdata_o),
        .hyp_req_wstrb_o(hyp_req_wstrb_o),
        .hyp_rsp_ready_i(hyp_rsp_ready_i), .hyp_rsp_rdata_i(hyp_rsp_rdata_i),
        .hyp_rsp_error_i(hyp_rsp_error_i),
        .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [47:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } xfer_t;

    xfer_t log_q[$];
    xfer_t exp_q[$];

    int checks = 0;
    int failures = 0;

    // Slave knobs (written by the test sequence only).
    int ready_mode = 0;   // 0: always ready, 1: random, 2: ready after 3 valid cycles
    int k_ready = 0;      // polls answered not-ready before the status bit sets
    int err_at = -1;      // transfer index answered with error

    // Slave-owned state.
    int cyc = 0;
    int nxfer = 0;
    int nread = 0;
    int vcnt = 0;
    int done_cyc = -1;
    logic [31:0] s_r;
    bit          s_rdy;
    xfer_t       s_x;

    // HyperBus slave: decide the response for this cycle and log transfers that will complete.
    always @(negedge clk) begin
        cyc++;
        if (!rst_ni) begin
            log_q.delete();
            nxfer = 0;
            nread = 0;
            done_cyc = -1;
        end
        if (hyp_req_valid_o) vcnt++; else vcnt = 0;
        if (done_o && done_cyc < 0) done_cyc = cyc;
        case (ready_mode)
            0:       s_rdy = 1'b1;
            1:       s_rdy = ($urandom_range(0, 1) == 1);
            default: s_rdy = (vcnt >= 3);
        endcase
        s_r = $urandom();
        s_r[0] = (nread >= k_ready);
        hyp_rsp_ready_i = s_rdy;
        hyp_rsp_error_i = (nxfer == err_at);
        hyp_rsp_rdata_i = s_r;
        if (hyp_req_valid_o && s_rdy) begin
            s_x.wr    = hyp_req_write_o;
            s_x.addr  = hyp_req_addr_o;
            s_x.wdata = hyp_req_wdata_o;
            s_x.wstrb = hyp_req_wstrb_o;
            s_x.cyc   = cyc;
            log_q.push_back(s_x);
            nxfer++;
            if (!hyp_req_write_o) nread++;
        end
    end

    // Expected transfer list from the boot rules; returns 1 for a DONE outcome, 0 for FAIL.
    function automatic bit build_model(input int k, input int err);
        xfer_t e;
        int n = 0;
        exp_q.delete();
        e.cyc = 0;
        for (int i = 0; i < NCFG; i++) begin
            e.wr = 1'b1; e.addr = BASE + 48'(4 * i); e.wdata = CFG_TBL[i]; e.wstrb = 4'hF;
            exp_q.push_back(e);
            if (n == err) return 1'b0;
            n++;
        end
        for (int p = 0; p < MAXP; p++) begin
            e.wr = 1'b0; e.addr = BASE + 48'h10; e.wdata = '0; e.wstrb = 4'h0;
            exp_q.push_back(e);
            if (n == err) return 1'b0;
            n++;
            if (p >= k) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Index of the first logged transfer (from base) that differs from the model, -1 if none.
    function automatic int first_diff(input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= log_q.size()) return i;
            if (log_q[base+i].wr !== exp_q[i].wr || log_q[base+i].addr !== exp_q[i].addr ||
                log_q[base+i].wstrb !== exp_q[i].wstrb ||
                (exp_q[i].wr && log_q[base+i].wdata !== exp_q[i].wdata)) return i;
        end
        return -1;
    endfunction

    task automatic assert_reset();
        @(posedge clk); #1;
        rst_ni = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic wait_flags(input int budget, output bit expired);
        expired = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_o || error_o) begin
                expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic soc_xfer(input bit wr, input logic [47:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input bit rerun, input int budget,
                            output bit ok, output logic [31:0] s_rd, output logic [31:0] h_rd,
                            output bit s_err, output bit flag_done);
        ok = 1'b0; s_rd = '0; h_rd = '0; s_err = 1'b0; flag_done = 1'b0;
        @(posedge clk); #1;
        soc_req_valid_i = 1'b1; soc_req_write_i = wr; soc_req_addr_i = a;
        soc_req_wdata_i = wd; soc_req_wstrb_i = ws; rerun_i = rerun;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (soc_rsp_ready_o) begin
                ok = 1'b1; s_rd = soc_rsp_rdata_o; h_rd = hyp_rsp_rdata_i;
                s_err = soc_rsp_error_o; flag_done = done_o;
                break;
            end
            @(posedge clk); #1;
            rerun_i = 1'b0;
        end
        @(posedge clk); #1;
        soc_req_valid_i = 1'b0;
        rerun_i = 1'b0;
    endtask

    task automatic test_reset();
        ready_mode = 0; k_ready = 0; err_at = -1;
        rst_ni = 1'b0;
        soc_req_valid_i = 1'b1; soc_req_write_i = 1'b0; soc_req_addr_i = BASE + 48'h10;
        soc_req_wdata_i = $urandom(); soc_req_wstrb_i = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({hyp_req_valid_o, hyp_req_write_o, hyp_req_addr_o, hyp_req_wdata_o, hyp_req_wstrb_o} !== 86'd0) begin
            failures++;
            $display("FAIL reset_hyp_req got v=%b w=%b a=%h d=%h s=%h exp all zero", hyp_req_valid_o,
                     hyp_req_write_o, hyp_req_addr_o, hyp_req_wdata_o, hyp_req_wstrb_o);
        end
        checks++;
        if ({soc_rsp_ready_o, soc_rsp_rdata_o, soc_rsp_error_o} !== 34'd0) begin
            failures++;
            $display("FAIL reset_soc_rsp got rdy=%b rd=%h err=%b exp all zero", soc_rsp_ready_o,
                     soc_rsp_rdata_o, soc_rsp_error_o);
        end
        checks++;
        if ({done_o, error_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got done=%b err=%b exp 0 0", done_o, error_o);
        end
        soc_req_valid_i = 1'b0;
    endtask

    task automatic test_basic();
        bit expired, exp_done;
        int bad = 0;
        ready_mode = 0; k_ready = 0; err_at = -1;
        release_reset();
        wait_flags(200, expired);
        exp_done = build_model(0, -1);
        checks++;
        if (expired || done_o !== exp_done || error_o !== !exp_done) begin
            failures++;
            $display("FAIL basic_flags got done=%b err=%b exp done=%b", done_o, error_o, exp_done);
        end
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=%0d", log_q.size(), exp_q.size());
        end
        checks++;
        if (first_diff(0) != -1) begin
            failures++;
            $display("FAIL basic_seq first bad transfer=%0d exp none", first_diff(0));
        end
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].cyc != log_q[0].cyc + i) bad++;
        checks++;
        if (bad != 0 || log_q.size() == 0) begin
            failures++;
            $display("FAIL basic_back_to_back got gaps=%0d exp 0", bad);
        end
        checks++;
        if (log_q.size() == 0 || done_cyc != log_q[log_q.size()-1].cyc + 1) begin
            failures++;
            $display("FAIL basic_done_timing got cyc=%0d exp last_poll+1", done_cyc);
        end
    endtask

    task automatic test_poll_gap();
        bit expired, exp_done;
        int bad = 0;
        assert_reset();
        ready_mode = 0; k_ready = 3; err_at = -1;
        release_reset();
        wait_flags(500, expired);
        exp_done = build_model(3, -1);
        checks++;
        if (expired || done_o !== 1'b1 || error_o !== 1'b0 || !exp_done) begin
            failures++;
            $display("FAIL gap_flags got done=%b err=%b exp 1 0", done_o, error_o);
        end
        checks++;
        if (log_q.size() != exp_q.size() || first_diff(0) != -1) begin
            failures++;
            $display("FAIL gap_seq got n=%0d exp n=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 5; i < log_q.size(); i++)
            if (log_q[i].cyc - log_q[i-1].cyc != 17) bad++;
        checks++;
        if (bad != 0 || log_q.size() < 8) begin
            failures++;
            $display("FAIL gap_spacing got bad=%0d exp 16 idle cycles between polls", bad);
        end
    endtask

    task automatic test_timeout();
        bit expired, exp_done, ok, s_err, fd;
        logic [31:0] s_rd, h_rd;
        logic [47:0] a;
        assert_reset();
        ready_mode = 0; k_ready = 1000; err_at = -1;
        release_reset();
        wait_flags(6000, expired);
        exp_done = build_model(1000, -1);
        checks++;
        if (expired || error_o !== 1'b1 || done_o !== 1'b0 || exp_done) begin
            failures++;
            $display("FAIL timeout_flags got done=%b err=%b exp 0 1", done_o, error_o);
        end
        checks++;
        if (log_q.size() != NCFG + MAXP || first_diff(0) != -1) begin
            failures++;
            $display("FAIL timeout_polls got n=%0d exp=%0d", log_q.size(), NCFG + MAXP);
        end
        a = BASE + 48'h100 + 48'(4 * $urandom_range(0, 63));
        soc_xfer(1'b0, a, 32'h0, 4'h0, 1'b0, 50, ok, s_rd, h_rd, s_err, fd);
        checks++;
        if (!ok || log_q.size() == 0 || log_q[log_q.size()-1].addr !== a || log_q[log_q.size()-1].wr !== 1'b0) begin
            failures++;
            $display("FAIL timeout_passthru got ok=%b exp read at %h forwarded", ok, a);
        end
        checks++;
        if (s_rd !== h_rd || s_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rdata got=%h err=%b exp=%h err=0", s_rd, s_err, h_rd);
        end
    endtask

    task automatic test_slave_error();
        bit expired, exp_done, ok, s_err, fd;
        logic [31:0] s_rd, h_rd, wd;
        logic [47:0] a;
        logic [3:0]  ws;
        assert_reset();
        ready_mode = 1; k_ready = 0; err_at = 1;
        release_reset();
        wait_flags(300, expired);
        exp_done = build_model(0, 1);
        checks++;
        if (expired || error_o !== 1'b1 || done_o !== 1'b0 || exp_done) begin
            failures++;
            $display("FAIL slverr_flags got done=%b err=%b exp 0 1", done_o, error_o);
        end
        checks++;
        if (log_q.size() != exp_q.size() || first_diff(0) != -1) begin
            failures++;
            $display("FAIL slverr_seq got n=%0d exp=%0d", log_q.size(), exp_q.size());
        end
        a = BASE + 48'h200 + 48'(4 * $urandom_range(0, 63));
        soc_xfer(1'b0, a, 32'h0, 4'h0, 1'b0, 100, ok, s_rd, h_rd, s_err, fd);
        checks++;
        if (!ok || log_q[log_q.size()-1].addr !== a || log_q[log_q.size()-1].wr !== 1'b0 || s_rd !== h_rd) begin
            failures++;
            $display("FAIL slverr_soc_read got ok=%b rd=%h exp read at %h rd=%h", ok, s_rd, a, h_rd);
        end
        err_at = nxfer;
        wd = $urandom(); ws = 4'($urandom_range(1, 15));
        soc_xfer(1'b1, a + 48'h4, wd, ws, 1'b0, 100, ok, s_rd, h_rd, s_err, fd);
        checks++;
        if (!ok || log_q[log_q.size()-1].wdata !== wd || log_q[log_q.size()-1].wstrb !== ws ||
            log_q[log_q.size()-1].wr !== 1'b1 || s_err !== 1'b1) begin
            failures++;
            $display("FAIL slverr_soc_write got ok=%b err=%b exp wdata=%h wstrb=%h err=1", ok, s_err, wd, ws);
        end
        err_at = -1;
    endtask

    task automatic test_soc_stall();
        bit ok, s_err, fd, exp_done;
        logic [31:0] s_rd, h_rd;
        logic [47:0] a;
        int k;
        assert_reset();
        k = int'($urandom_range(0, 3));
        ready_mode = 1; k_ready = k; err_at = -1;
        release_reset();
        a = BASE + 48'h300 + 48'(4 * $urandom_range(0, 63));
        soc_xfer(1'b0, a, 32'h0, 4'h0, 1'b0, 1000, ok, s_rd, h_rd, s_err, fd);
        exp_done = build_model(k, -1);
        checks++;
        if (!ok || fd !== 1'b1 || !exp_done) begin
            failures++;
            $display("FAIL stall_ready_before_done got ok=%b done_at_ready=%b exp 1 1", ok, fd);
        end
        checks++;
        if (log_q.size() != exp_q.size() + 1 || first_diff(0) != -1 || log_q[log_q.size()-1].addr !== a) begin
            failures++;
            $display("FAIL stall_forward got n=%0d exp=%0d with SoC read last", log_q.size(), exp_q.size() + 1);
        end
        checks++;
        if (s_rd !== h_rd) begin
            failures++;
            $display("FAIL stall_rdata got=%h exp=%h", s_rd, h_rd);
        end
    endtask

    task automatic test_random();
        bit expired, exp_done;
        int k, e;
        for (int it = 0; it < 6; it++) begin
            assert_reset();
            k = int'($urandom_range(0, 4));
            e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            ready_mode = 1; k_ready = k; err_at = e;
            release_reset();
            wait_flags(1000, expired);
            exp_done = build_model(k, e);
            checks++;
            if (expired || done_o !== exp_done || error_o !== !exp_done) begin
                failures++;
                $display("FAIL rand%0d_flags k=%0d err=%0d got done=%b err=%b exp done=%b", it, k, e,
                         done_o, error_o, exp_done);
            end
            checks++;
            if (log_q.size() != exp_q.size() || first_diff(0) != -1) begin
                failures++;
                $display("FAIL rand%0d_seq got n=%0d exp=%0d", it, log_q.size(), exp_q.size());
            end
        end
        err_at = -1;
    endtask

    task automatic test_reset_rerun();
        bit expired, exp_done, seen, ok, s_err, fd;
        logic [31:0] s_rd, h_rd;
        logic [47:0] a;
        int L;
        assert_reset();
        ready_mode = 2; k_ready = 1000; err_at = -1;
        release_reset();
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (log_q.size() >= NCFG + 1 && hyp_req_valid_o && !hyp_req_write_o && vcnt == 1) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (!seen || hyp_req_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL midpoll_reset_valid got seen=%b valid=%b exp 1 0", seen, hyp_req_valid_o);
        end
        k_ready = 0;
        release_reset();
        wait_flags(500, expired);
        exp_done = build_model(0, -1);
        checks++;
        if (expired || done_o !== 1'b1 || log_q.size() != exp_q.size() || first_diff(0) != -1 || !exp_done) begin
            failures++;
            $display("FAIL restart_seq got done=%b n=%0d exp done=1 n=%0d from write 0", done_o,
                     log_q.size(), exp_q.size());
        end
        L = log_q.size();
        a = BASE + 48'h400 + 48'(4 * $urandom_range(0, 63));
        soc_xfer(1'b0, a, 32'h0, 4'h0, 1'b1, 50, ok, s_rd, h_rd, s_err, fd);
        checks++;
        if (!ok || fd !== 1'b1) begin
            failures++;
            $display("FAIL rerun_deferred got ok=%b done_during_xfer=%b exp 1 1", ok, fd);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!done_o) begin
                seen = 1'b1;
                break;
            end
        end
        wait_flags(500, expired);
        checks++;
        if (!seen || expired || done_o !== 1'b1 || log_q.size() != L + 1 + exp_q.size() ||
            log_q[L].addr !== a || first_diff(L + 1) != -1) begin
            failures++;
            $display("FAIL rerun_seq got restarted=%b done=%b n=%0d exp 1 1 n=%0d", seen, done_o,
                     log_q.size(), L + 1 + exp_q.size());
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        rerun_i = 1'b0;
        soc_req_valid_i = 1'b0;
        soc_req_write_i = 1'b0;
        soc_req_addr_i = '0;
        soc_req_wdata_i = '0;
        soc_req_wstrb_i = '0;
        test_reset();
        test_basic();
        test_poll_gap();
        test_timeout();
        test_slave_error();
        test_soc_stall();
        test_random();
        test_reset_rerun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
